// File: rtl/sample_framer_if.sv
// Sample-record input channel, UART byte channel and framer status, bundled.
// The framer connects through the master modport; the feeding/consuming
// logic (or a testbench) uses the slave modport.
interface sample_framer_if #(
    parameter int PAYLOAD_BYTES = 16
);
    // Sample record channel (into the framer)
    logic                       smp_valid_i;
    logic [PAYLOAD_BYTES*8-1:0] smp_data_i;
    logic                       smp_ready_o;

    // Byte channel towards the UART transmitter
    logic [7:0]                 tx_data_o;
    logic                       tx_valid_o;
    logic                       tx_ready_i;

    // Status
    logic                       frame_busy_o;
    logic [7:0]                 seq_o;
    logic [7:0]                 drop_cnt_o;

    modport master (
        input  smp_valid_i, smp_data_i, tx_ready_i,
        output smp_ready_o, tx_data_o, tx_valid_o, frame_busy_o, seq_o, drop_cnt_o
    );

    modport slave (
        output smp_valid_i, smp_data_i, tx_ready_i,
        input  smp_ready_o, tx_data_o, tx_valid_o, frame_busy_o, seq_o, drop_cnt_o
    );
endinterface

// File: rtl/sample_framer.sv
// sample_framer: captures one sample record and serialises it as a byte frame
//   A5 5A <seq> <payload MSB byte first ...> [<crc8>]
// for a byte-wide UART transmitter with a valid/ready handshake.
// Optional feature: define SAMPLE_FRAMER_CRC_EN to append a CRC-8 byte
// (poly 0x07, init 0x00, no reflection, no final XOR) over seq + payload.
module sample_framer #(
    parameter int PAYLOAD_BYTES = 16
) (
    input  logic            ref_clk_buf,
    input  logic            rst,
    sample_framer_if.master bus
);

    localparam int               IDX_W     = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PAYLOAD_BYTES - 1);
    localparam logic [7:0]       HDR0_BYTE = 8'hA5;
    localparam logic [7:0]       HDR1_BYTE = 8'h5A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_SEQ,
        S_PAYLOAD
`ifdef SAMPLE_FRAMER_CRC_EN
        ,
        S_CRC
`endif
    } state_t;

    state_t                     state_q, state_d;
    logic [PAYLOAD_BYTES*8-1:0] shadow_q, shadow_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [7:0]                 seq_q, seq_d;
    logic [7:0]                 drop_q, drop_d;
    // Holds smp_ready low until the first edge after reset is released.
    logic                       init_q, init_d;
`ifdef SAMPLE_FRAMER_CRC_EN
    logic [7:0]                 crc_q, crc_d;
`endif

    logic [7:0] pay_bytes [PAYLOAD_BYTES];
    logic       smp_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       capture;
    logic       accept;
    logic       last_byte;

`ifdef SAMPLE_FRAMER_CRC_EN
    // One CRC-8 (poly 0x07) update step over a whole byte, MSB first.
    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction
`endif

    // Payload bytes in transmit order: index 0 is the most significant byte.
    for (genvar i = 0; i < PAYLOAD_BYTES; i++) begin : g_pay_bytes
        assign pay_bytes[i] = shadow_q[8*(PAYLOAD_BYTES-1-i) +: 8];
    end

    assign capture   = bus.smp_valid_i && smp_ready;
    assign accept    = tx_valid && bus.tx_ready_i;
`ifdef SAMPLE_FRAMER_CRC_EN
    assign last_byte = accept && (state_q == S_CRC);
`else
    assign last_byte = accept && (state_q == S_PAYLOAD) && (idx_q == LAST_IDX);
`endif

    // State register.
    // NOTE: sequential blocks use non-blocking assignments only, so every flop
    // samples the values computed before the edge, regardless of block order.
    always_ff @(posedge ref_clk_buf or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: each step waits for the UART to take the current byte.
    // NOTE: every combinational output gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (capture) state_d = S_HDR0;
            S_HDR0:    if (accept)  state_d = S_HDR1;
            S_HDR1:    if (accept)  state_d = S_SEQ;
            S_SEQ:     if (accept)  state_d = S_PAYLOAD;
            S_PAYLOAD: begin
                if (accept && (idx_q == LAST_IDX)) begin
`ifdef SAMPLE_FRAMER_CRC_EN
                    state_d = S_CRC;
`else
                    state_d = S_IDLE;
`endif
                end
            end
`ifdef SAMPLE_FRAMER_CRC_EN
            S_CRC:     if (accept)  state_d = S_IDLE;
`endif
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state: the byte on offer and the handshake flags.
    always_comb begin
        smp_ready = init_q && (state_q == S_IDLE);
        tx_valid  = (state_q != S_IDLE);
        tx_data   = 8'h00;
        case (state_q)
            S_HDR0:    tx_data = HDR0_BYTE;
            S_HDR1:    tx_data = HDR1_BYTE;
            S_SEQ:     tx_data = seq_q;
            S_PAYLOAD: tx_data = pay_bytes[idx_q];
`ifdef SAMPLE_FRAMER_CRC_EN
            S_CRC:     tx_data = crc_q;
`endif
            default:   tx_data = 8'h00;
        endcase
    end

    // Datapath next values: shadow capture, byte index, sequence, drops, CRC.
    always_comb begin
        shadow_d = capture ? bus.smp_data_i : shadow_q;

        idx_d = idx_q;
        if (capture) begin
            idx_d = '0;
        end else if (accept && (state_q == S_PAYLOAD)) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end

        seq_d = last_byte ? seq_q + 8'd1 : seq_q;

        // A record offered while not ready is lost; the counter sticks at 0xFF.
        drop_d = drop_q;
        if (bus.smp_valid_i && !smp_ready && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end

        init_d = 1'b1;

`ifdef SAMPLE_FRAMER_CRC_EN
        crc_d = crc_q;
        if (capture) begin
            crc_d = 8'h00;
        end else if (accept && ((state_q == S_SEQ) || (state_q == S_PAYLOAD))) begin
            crc_d = crc8_next(crc_q, tx_data);
        end
`endif
    end

    // Datapath registers.
    // NOTE: the shadow record is cleared on reset as well, so no stale sample
    // data can leak out after a reset.
    always_ff @(posedge ref_clk_buf or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            idx_q    <= '0;
            seq_q    <= 8'h00;
            drop_q   <= 8'h00;
            init_q   <= 1'b0;
`ifdef SAMPLE_FRAMER_CRC_EN
            crc_q    <= 8'h00;
`endif
        end else begin
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            seq_q    <= seq_d;
            drop_q   <= drop_d;
            init_q   <= init_d;
`ifdef SAMPLE_FRAMER_CRC_EN
            crc_q    <= crc_d;
`endif
        end
    end

    assign bus.smp_ready_o  = smp_ready;
    assign bus.tx_valid_o   = tx_valid;
    assign bus.tx_data_o    = tx_data;
    assign bus.frame_busy_o = (state_q != S_IDLE);
    assign bus.seq_o        = seq_q;
    assign bus.drop_cnt_o   = drop_q;

endmodule

// File: doc/sample_framer.md
SAMPLE_FRAMER -- requirements
Module: sample_framer

Interface
REQ-001 SHALL have parameter PAYLOAD_BYTES, default 16: number of payload bytes per captured sample record.
REQ-002 SHALL have clock ref_clk_buf (input, 1): the only clock; all logic is rising-edge.
REQ-003 SHALL have reset rst (input, 1): reset, asynchronous, active-high.
REQ-004 SHALL have smp_valid_i (input, 1): sample record offered.
REQ-005 SHALL have smp_data_i (input, PAYLOAD_BYTES*8): sample record (3 osc counters, temperature, pad).
REQ-006 SHALL have smp_ready_o (output, 1): framer can accept a record.
REQ-007 SHALL have tx_data_o (output, 8): byte to the byte-wide UART transmitter.
REQ-008 SHALL have tx_valid_o (output, 1): tx_data_o is valid.
REQ-009 SHALL have tx_ready_i (input, 1): UART accepts the byte.
REQ-010 SHALL have frame_busy_o (output, 1): a frame is in progress.
REQ-011 SHALL have seq_o (output, 8): sequence number of the next frame.
REQ-012 SHALL have drop_cnt_o (output, 8): count of records dropped while busy.

Function
REQ-013 SHALL implement the FSM IDLE -> HDR0 -> HDR1 -> SEQ -> PAYLOAD -> [CRC] -> IDLE.
REQ-014 SHALL assert smp_ready_o only in IDLE and SHALL capture smp_data_i into an internal shadow register on the cycle smp_valid_i && smp_ready_o.
REQ-015 SHALL, after a capture on edge N, present tx_valid_o=1 with tx_data_o=0xA5 (HDR0) from edge N+1.
REQ-016 SHALL emit, in order: 0xA5, 0x5A, seq byte, then payload MSB byte first (bits [PAYLOAD_BYTES*8-1 -: 8] first, bits [7:0] last).
REQ-017 SHALL advance to the next byte only on a cycle with tx_valid_o && tx_ready_i.
REQ-018 SHALL hold tx_data_o stable and tx_valid_o high while tx_ready_i=0, with no timeout.
REQ-019 SHALL deassert tx_valid_o on the edge after the last byte of a frame is accepted, returning to IDLE with smp_ready_o=1.
REQ-020 SHALL produce no idle gap between bytes inside a frame when tx_ready_i stays high (one byte per cycle).
REQ-021 SHALL use a payload byte index counting 0..PAYLOAD_BYTES-1 and SHALL leave PAYLOAD on acceptance of index PAYLOAD_BYTES-1.
REQ-022 SHALL increment seq_o by 1 (mod 256, 0xFF wraps to 0x00) on the edge the last byte of a frame is accepted; the seq byte sent equals seq_o at capture time.
REQ-023 SHALL increment drop_cnt_o by 1 for each cycle with smp_valid_i=1 and smp_ready_o=0.
REQ-024 SHALL saturate drop_cnt_o at 0xFF.
REQ-025 SHALL assert frame_busy_o in every state except IDLE.
REQ-026 SHALL leave the shadow register unchanged by smp_data_i changes during a frame.
REQ-027 SHALL, when frame completion and smp_valid_i coincide, not capture on that edge and SHALL count it as a drop; the record may be captured on the next cycle if smp_valid_i is still high.

Reset
REQ-028 SHALL, on rst assertion at any time (including mid-frame), immediately force state=IDLE, tx_valid_o=0, tx_data_o=0x00, smp_ready_o=0, frame_busy_o=0, seq_o=0x00, drop_cnt_o=0x00 and shadow register=0.
REQ-029 SHALL drive smp_ready_o=1 from the first edge after rst deasserts.
REQ-030 SHALL not resume an aborted frame after reset.

Configuration
REQ-031 SHALL, when macro SAMPLE_FRAMER_CRC_EN is defined, append one CRC byte after the payload.
REQ-032 SHALL compute that CRC as CRC-8, polynomial 0x07, init 0x00, no reflection, no final XOR, over the seq byte and all payload bytes, updated on each accepted byte.
REQ-033 SHALL give a total frame length of PAYLOAD_BYTES+4 with SAMPLE_FRAMER_CRC_EN defined.
REQ-034 SHALL, without SAMPLE_FRAMER_CRC_EN, omit the CRC state and CRC logic entirely, with frame length PAYLOAD_BYTES+3.

Verification
REQ-035 SHALL cover: reset, payload all 0x00, tx_ready_i=1 constant -> bytes A5 5A 00 00x16 [00 with CRC]; tx_valid_o high 19/20 consecutive cycles; seq_o=0x01 afterwards.
REQ-036 SHALL cover: payload 0x0102...10 with tx_ready_i toggling 1/0 -> payload emitted 01,02,...,10 in order; each byte held stable while tx_ready_i=0; CRC equal to the software model.
REQ-037 SHALL cover: smp_valid_i held high for 5 cycles during an active frame -> drop_cnt_o=5; the in-flight payload is unchanged.
REQ-038 SHALL cover: 256 back-to-back frames -> seq bytes 00..FF, then 257th frame seq=00.
REQ-039 SHALL cover: rst pulsed during PAYLOAD index 7 -> tx_valid_o=0 asynchronously, seq_o=0, next capture starts with A5 5A 00.
REQ-040 SHALL cover: drop_cnt_o driven with 300 drop cycles -> drop_cnt_o=0xFF.
